uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Receive front end of the UART path. Oversamples the asynchronous serial line, finds start bits, and recovers each frame of 8 data bits (LSB first), one parity bit and one stop bit. Delivers the raw 9-bit word {parity, data[7:0]} to the 8-bit parity checker, which sits directly downstream. Parity is not evaluated here: the word is passed through unchanged. Stop-bit violations are flagged as framing errors and are not delivered.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; must be even and ≥ 4.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line; asynchronous, idles high.
- data  output  9  received word: [8] = parity bit as received, [7:0] = data byte (bit 0 received first). Holds its value until the next good frame.
- data_valid  output  1  one-cycle pulse; `data` is valid on the same cycle.
- framing_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- rx passes through a 2-flop synchronizer: rx_s = rx delayed 2 cycles, with reset value 1. All decisions use rx_s only.
- States and transitions:
  - IDLE: when rx_s == 0, go to START and clear the cycle counter.
  - START: count N/2 cycles, then sample rx_s. If it is 0, go to DATA with bit index 0. If it is 1, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every N cycles. Shift the sample into shift[bit index]. After the 8th sample, go to PARITY.
  - PARITY: after N cycles, sample into shift[8] and go to STOP.
  - STOP: after N cycles, sample rx_s.
    - If 1: register data ← shift, pulse data_valid, go to IDLE.
    - If 0: pulse framing_err, leave data unchanged, go to BREAK.
  - BREAK: wait until rx_s == 1, then go to IDLE.
- Each data, parity and stop sample lands at the nominal mid-bit point.
- Returning to IDLE at mid-stop allows back-to-back frames with one stop bit.
- data_valid and framing_err are never high on the same cycle. Neither pulse lasts more than one cycle.
- Asserting rst_n at any time (including mid-frame) clears all state immediately. The partial frame is discarded with no pulse.

## Timing
- Reset values: data = 9'h000, data_valid = 0, framing_err = 0, busy = 0, state = IDLE, rx_s = 1.
- Cycle numbering: cycle 0 is the first rising edge at which rx is sampled low.
- rx_s is low at cycle 2; IDLE → START at that edge, so busy = 1 from cycle 3.
- With N = CLKS_PER_BIT:
  - start sample at cycle 2 + N/2
  - data bit k sampled at cycle 2 + N/2 + (k+1)·N
  - parity sampled at cycle 2 + N/2 + 9N
  - stop sampled at cycle 2 + N/2 + 10N
- data_valid or framing_err is high during cycle 3 + N/2 + 10N. busy is low in that same cycle for a good frame.
- For N = 16: start sample at 10, stop sample at 170, pulse at 171.
- A new falling edge is accepted on the first cycle after the return to IDLE.
- Glitch rejection: a low pulse shorter than N/2 − 2 cycles never reaches DATA.

## Test plan
- Reset mid-frame: rst_n low for 2 cycles during DATA → busy = 0 immediately and no pulse. A following clean frame (data 0x0F, parity 0) → data = 9'b000001111.
- Good frame (N = 16): rx sends start, byte 0xBF LSB first, parity 1, stop 1 with the falling edge at cycle 0 → data_valid high at cycle 171 only, data = 9'b110111111, framing_err never high.
- Pass-through of bad parity: byte 0xFF, parity 1 → data = 9'b111111111 with data_valid (no parity check here).
- Glitch: rx low for 4 cycles then high → busy returns to 0 by cycle 11, no data_valid or framing_err, data unchanged.
- Framing error: byte 0x4F, parity 1, stop 0, then line held low for 40 cycles → framing_err pulses once at cycle 171, data holds its previous value, busy stays 1 until 3 cycles after rx rises.
- Back-to-back: frames 0x0F/p0 then 0x4F/p1 with one stop bit each and no idle gap → two data_valid pulses 176 cycles apart, carrying 9'b000001111 then 9'b101001111.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// Receive front end of the UART path. The serial line is synchronised,
// start bits are qualified at mid-bit, and each frame of 8 data bits
// (LSB first), one parity bit and one stop bit is recovered. The raw
// 9-bit word {parity, data[7:0]} is handed on unchanged. A low stop bit
// raises a one-cycle framing error, and that frame is not delivered.

module uart_rx_deserializer #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [8:0] data,
   output logic       data_valid,
   output logic       framing_err,
   output logic       busy
);

   // Counter width covers 0 .. CLKS_PER_BIT-1.
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   logic [1:0]    sync_q;
   logic          rx_s;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [8:0]    shift_q;
   logic [8:0]    data_q;
   logic          valid_q;
   logic          ferr_q;
   logic          busy_q;

   logic          half_tick;
   logic          full_tick;

   // Two-flop synchroniser for the asynchronous serial line; idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   // Synchronised line and the half-bit / full-bit sample points.
   always_comb begin
      rx_s      = sync_q[1];
      half_tick = (cnt_q == HALF_LAST);
      full_tick = (cnt_q == FULL_LAST);
   end

   // Frame recovery state machine with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  state_q <= S_START;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end

            S_START: begin
               if (half_tick) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     // Line went back high before mid-start: a glitch.
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_DATA;
                     idx_q   <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            S_DATA: begin
               if (full_tick) begin
                  cnt_q                  <= '0;
                  shift_q[{1'b0, idx_q}] <= rx_s;
                  if (idx_q == 3'd7) begin
                     state_q <= S_PARITY;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            S_PARITY: begin
               if (full_tick) begin
                  cnt_q      <= '0;
                  shift_q[8] <= rx_s;
                  state_q    <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            S_STOP: begin
               if (full_tick) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     // Returning at mid-stop leaves half a bit to catch
                     // the next start edge of a back-to-back frame.
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= S_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            S_BREAK: begin
               if (rx_s) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Drive outputs straight from their registers.
   always_comb begin
      data        = data_q;
      data_valid  = valid_q;
      framing_err = ferr_q;
      busy        = busy_q;
   end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Testbench for uart_rx_deserializer. The whole rx / rst_n waveform is
// built up front; a frame-level model then derives, from the sample-point
// arithmetic, what every output must be after every clock edge. One
// process drives the waveform, another compares the DUT every cycle.

module tb_uart_rx_deserializer;

   localparam int N = 16;
   localparam int H = N / 2;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [8:0] data;
   logic       data_valid;
   logic       framing_err;
   logic       busy;

   int checks;
   int errors;

   uart_rx_deserializer #(.CLKS_PER_BIT(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data       (data),
      .data_valid (data_valid),
      .framing_err(framing_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus: value of rx and rst_n seen at each rising edge.
   bit line[$];
   bit rstv[$];
   int T;

   // Expected outputs just after each rising edge.
   bit         eb[];
   bit         ev[];
   bit         ef[];
   logic [8:0] ed[];

   typedef struct {
      int         e;
      int         what;
      logic [8:0] v;
   } pin_t;
   pin_t pins[$];

   task automatic push(bit v, int n);
      for (int i = 0; i < n; i++) begin
         line.push_back(v);
         rstv.push_back(1'b1);
      end
   endtask

   task automatic push_frame(logic [7:0] b, bit p, bit stp);
      push(1'b0, N);
      for (int k = 0; k < 8; k++) push(b[k], N);
      push(p, N);
      push(stp, N);
   endtask

   task automatic pin(int e, int what, logic [8:0] v);
      pin_t p;
      p.e = e; p.what = what; p.v = v;
      pins.push_back(p);
   endtask

   // Synchronised line value the receiver sees at edge e.
   function automatic bit rxs(int e);
      if (e < 2 || e >= T) return 1'b1;
      if (!rstv[e-1] || !rstv[e-2]) return 1'b1;
      return line[e-2];
   endfunction

   function automatic void setx(int e, bit b, bit v, bit f, logic [8:0] d);
      if (e >= 0 && e < T) begin
         eb[e] = b; ev[e] = v; ef[e] = f; ed[e] = d;
      end
   endfunction

   // Frame-level reference: locate each start, read every field at its
   // mid-bit edge, and fill in the expected outputs for the whole frame.
   task automatic build_model();
      int e;
      logic [8:0] dm;
      eb = new[T]; ev = new[T]; ef = new[T]; ed = new[T];
      e  = 0;
      dm = '0;
      while (e < T) begin
         if (!rstv[e]) begin
            dm = '0;
            setx(e, 1'b0, 1'b0, 1'b0, dm);
            e++;
         end else if (rxs(e)) begin
            setx(e, 1'b0, 1'b0, 1'b0, dm);
            e++;
         end else begin
            int s, ss, se, endE, kind, r;
            logic [8:0] w;
            s    = e;
            ss   = s + H;
            se   = ss + 10 * N;
            w    = '0;
            kind = 0;
            if (rxs(ss)) begin
               endE = ss;
            end else begin
               for (int k = 0; k < 8; k++) w[k] = rxs(ss + (k + 1) * N);
               w[8] = rxs(ss + 9 * N);
               if (rxs(se)) begin
                  kind = 1;
                  endE = se;
               end else begin
                  kind = 2;
                  endE = se + 1;
                  while (!rxs(endE)) endE++;
               end
            end
            r = -1;
            for (int i = s + 1; i <= endE && i < T; i++) begin
               if (!rstv[i]) begin
                  r = i;
                  break;
               end
            end
            if (r >= 0) begin
               for (int i = s; i < r; i++) setx(i, 1'b1, 1'b0, 1'b0, dm);
               e = r;
            end else begin
               for (int i = s; i <= endE; i++) setx(i, i != endE, 1'b0, 1'b0, dm);
               if (kind == 1) begin
                  dm = w;
                  setx(se, 1'b0, 1'b1, 1'b0, dm);
               end else if (kind == 2) begin
                  setx(se, 1'b1, 1'b0, 1'b1, dm);
               end
               e = endE + 1;
            end
         end
      end
   endtask

   task automatic chk(string nm, int e, logic [8:0] act, logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge %0d got %0h want %0h", nm, e, act, exp);
      end
   endtask

   task automatic build_stimulus();
      int c;
      // Power-up reset.
      for (int i = 0; i < 4; i++) begin
         line.push_back(1'b1);
         rstv.push_back(1'b0);
      end
      push(1'b1, 10);

      // Good frame 0xBF, parity 1.
      c = line.size();
      push_frame(8'hBF, 1'b1, 1'b1);
      push(1'b1, 30);
      pin(c + 1, 0, 9'd0);
      pin(c + 2, 0, 9'd1);
      pin(c + 169, 1, 9'd0);
      pin(c + 170, 1, 9'd1);
      pin(c + 170, 2, 9'd0);
      pin(c + 170, 3, 9'b110111111);
      pin(c + 170, 0, 9'd0);
      pin(c + 171, 1, 9'd0);

      // Parity passes through unchecked.
      c = line.size();
      push_frame(8'hFF, 1'b1, 1'b1);
      push(1'b1, 30);
      pin(c + 170, 1, 9'd1);
      pin(c + 170, 3, 9'b111111111);

      // Four-cycle glitch.
      c = line.size();
      push(1'b0, 4);
      push(1'b1, 30);
      pin(c + 9, 0, 9'd1);
      pin(c + 10, 0, 9'd0);
      pin(c + 10, 3, 9'h1FF);

      // Framing error followed by a 40-cycle break.
      c = line.size();
      push_frame(8'h4F, 1'b1, 1'b0);
      push(1'b0, 40);
      push(1'b1, 30);
      pin(c + 170, 2, 9'd1);
      pin(c + 170, 1, 9'd0);
      pin(c + 170, 3, 9'h1FF);
      pin(c + 171, 2, 9'd0);
      pin(c + 216 + 1, 0, 9'd1);
      pin(c + 216 + 2, 0, 9'd0);

      // Back-to-back frames, single stop bit, no idle gap.
      c = line.size();
      push_frame(8'h0F, 1'b0, 1'b1);
      push_frame(8'h4F, 1'b1, 1'b1);
      push(1'b1, 30);
      pin(c + 170, 1, 9'd1);
      pin(c + 170, 3, 9'b000001111);
      pin(c + 346, 1, 9'd1);
      pin(c + 346, 3, 9'b101001111);

      // Reset in the middle of the data bits, then a clean frame.
      c = line.size();
      push(1'b0, N);
      push(1'b1, N);
      push(1'b0, N);
      push(1'b1, N);
      push(1'b1, 40);
      rstv[c + 60] = 1'b0;
      rstv[c + 61] = 1'b0;
      pin(c + 59, 0, 9'd1);
      pin(c + 60, 0, 9'd0);
      pin(c + 60, 3, 9'd0);
      pin(c + 61, 1, 9'd0);
      c = line.size();
      push_frame(8'h0F, 1'b0, 1'b1);
      push(1'b1, 20);
      pin(c + 170, 1, 9'd1);
      pin(c + 170, 3, 9'b000001111);

      // Random traffic: frames, stop errors, glitches, stray resets.
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 5) == 0) begin
            push(1'b0, $urandom_range(1, 5));
            push(1'b1, $urandom_range(12, 20));
         end else begin
            int fs;
            bit stp;
            fs  = line.size();
            stp = ($urandom_range(0, 7) != 0);
            push_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), stp);
            if (!stp) begin
               push(1'b0, $urandom_range(0, 30));
               push(1'b1, $urandom_range(1, 10));
            end
            push(1'b1, $urandom_range(0, 12));
            if ($urandom_range(0, 11) == 0) begin
               int off;
               off = $urandom_range(5, 170);
               for (int i = 0; i < $urandom_range(1, 3); i++) rstv[fs + off + i] = 1'b0;
            end
         end
      end
      push(1'b1, 30);
      T = line.size();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      rx     = 1'b1;
      build_stimulus();
      build_model();
      @(negedge clk);
      fork
         begin
            for (int e = 0; e < T; e++) begin
               rx    = line[e];
               rst_n = rstv[e];
               @(posedge clk);
               #3;
            end
         end
         begin
            for (int e = 0; e < T; e++) begin
               @(posedge clk);
               #2;
               chk("busy", e, {8'd0, busy}, {8'd0, eb[e]});
               chk("data_valid", e, {8'd0, data_valid}, {8'd0, ev[e]});
               chk("framing_err", e, {8'd0, framing_err}, {8'd0, ef[e]});
               chk("data", e, data, ed[e]);
               foreach (pins[i]) begin
                  if (pins[i].e == e) begin
                     case (pins[i].what)
                        0:       chk("pin_busy", e, {8'd0, busy}, pins[i].v);
                        1:       chk("pin_valid", e, {8'd0, data_valid}, pins[i].v);
                        2:       chk("pin_ferr", e, {8'd0, framing_err}, pins[i].v);
                        default: chk("pin_data", e, data, pins[i].v);
                     endcase
                  end
               end
            end
         end
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
